// File: rtl/vedic_mul16_seq_if.sv
// Request/result bundle between a start/done requester and the sequenced 16x16 MAC.
interface vedic_mul16_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        acc_mode;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        ovf;

  modport master (
    output start, a, b, acc_mode,
    input  ready, busy, done, product, ovf
  );

  modport slave (
    input  start, a, b, acc_mode,
    output ready, busy, done, product, ovf
  );
endinterface

// File: rtl/vedic_mul16_seq.sv
// 16x16 unsigned multiply-accumulate over four passes through one shared 8x8 Vedic multiplier.
// Latency 5 cycles from acceptance to done; requests are only taken while ready is high.
module vedic_mul16_seq (
  input logic            clk,
  input logic            rst_n,
  vedic_mul16_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P0   = 3'd1;
  localparam logic [2:0] S_P1   = 3'd2;
  localparam logic [2:0] S_P2   = 3'd3;
  localparam logic [2:0] S_P3   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Urdhva-Tiryagbhyam building blocks: each level splits into four half-width products.
  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic t1, t2, c, h;
    t1 = x[1] & y[0];
    t2 = x[0] & y[1];
    c  = t1 & t2;
    h  = x[1] & y[1];
    return {h & c, h ^ c, t1 ^ t2, x[0] & y[0]};
  endfunction

  function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] p0, p1, p2, p3;
    p0 = vm2(x[1:0], y[1:0]);
    p1 = vm2(x[3:2], y[1:0]);
    p2 = vm2(x[1:0], y[3:2]);
    p3 = vm2(x[3:2], y[3:2]);
    return {p3, p0} + {2'b00, p1, 2'b00} + {2'b00, p2, 2'b00};
  endfunction

  function automatic logic [15:0] vm8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p0, p1, p2, p3;
    p0 = vm4(x[3:0], y[3:0]);
    p1 = vm4(x[7:4], y[3:0]);
    p2 = vm4(x[3:0], y[7:4]);
    p3 = vm4(x[7:4], y[7:4]);
    return {p3, p0} + {4'h0, p1, 4'h0} + {4'h0, p2, 4'h0};
  endfunction

  logic [2:0]  state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        acc_q, acc_d;
  logic [31:0] product_q, product_d;
  logic        ovf_q, ovf_d;

  logic [7:0]  op_a, op_b;
  logic [15:0] pp;
  logic [31:0] addend;
  logic [31:0] base;
  logic [32:0] sum;

  always_comb begin : VEDIC_MULTIPLIER_8_BIT
    op_a = (state_q == S_P2 || state_q == S_P3) ? a_q[15:8] : a_q[7:0];
    op_b = (state_q == S_P1 || state_q == S_P3) ? b_q[15:8] : b_q[7:0];
    pp   = vm8(op_a, op_b);
  end

  always_comb begin
    case (state_q)
      S_P0:       addend = {16'h0000, pp};
      S_P1, S_P2: addend = {8'h00, pp, 8'h00};
      S_P3:       addend = {pp, 16'h0000};
      default:    addend = 32'h0000_0000;
    endcase
    // A fresh multiply starts from zero even though acceptance already cleared the register.
    base = (state_q == S_P0 && !acc_q) ? 32'h0000_0000 : product_q;
    sum  = {1'b0, base} + {1'b0, addend};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = bus.acc_mode;
          ovf_d   = 1'b0;
          state_d = S_P0;
          if (!bus.acc_mode) product_d = 32'h0000_0000;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_P0, S_P1, S_P2, S_P3: begin
        product_d = sum[31:0];
        ovf_d     = ovf_q | sum[32];
        state_d   = (state_q == S_P3) ? S_DONE : state_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      acc_q     <= 1'b0;
      product_q <= 32'h0000_0000;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.ready   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.busy    = (state_q == S_P0) || (state_q == S_P1) ||
                       (state_q == S_P2) || (state_q == S_P3);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = product_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_vedic_mul16_seq.sv
// Self-checking bench for vedic_mul16_seq: vector table, random model-checked ops, handshake and reset corners.
module tb_vedic_mul16_seq;

  logic clk;
  logic rst_n;

  vedic_mul16_seq_if bus ();

  vedic_mul16_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        acc;
    logic [31:0] p;
    logic        o;
  } vec_t;

  typedef struct {
    logic [31:0] p;
    logic        o;
  } exp_t;

  vec_t vecs [7];
  exp_t sbq [$];

  int checks = 0;
  int errors = 0;
  logic [31:0] model_p = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_push(input logic [15:0] a, input logic [15:0] b, input logic acc);
    logic [32:0] s;
    exp_t e;
    s = (acc ? {1'b0, model_p} : 33'h0) + {1'b0, 32'(a) * 32'(b)};
    e.p = s[31:0];
    e.o = s[32];
    model_p = s[31:0];
    sbq.push_back(e);
  endtask

  task automatic sb_pop_check(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: done with empty scoreboard", name);
    end else begin
      e = sbq.pop_front();
      chk({name, ".product"}, bus.product, e.p);
      chk({name, ".ovf"}, {31'h0, bus.ovf}, {31'h0, e.o});
    end
  endtask

  // One operation from IDLE; optional start pulse with junk operands at cycle 'poke' after acceptance.
  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic acc, input int poke);
    int lat;
    int bcnt;
    bit got;
    @(negedge clk);
    chk({name, ".ready"}, {31'h0, bus.ready}, 32'h1);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.acc_mode = acc;
    expect_push(a, b, acc);
    @(negedge clk);
    lat = 0;
    bcnt = 0;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      lat++;
      bus.start = (lat == poke);
      if (lat == poke) begin
        bus.a = 16'hFFFF;
        bus.b = 16'hFFFF;
        bus.acc_mode = 1'b1;
      end
      if (bus.busy) bcnt++;
      if (bus.done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: no done within 20 cycles", name);
      void'(sbq.pop_front());
    end else begin
      chk({name, ".latency"}, lat, 5);
      chk({name, ".busy_cycles"}, bcnt, 4);
      sb_pop_check(name);
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 32'h0626_0060, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b0};
    vecs[2] = '{16'h0001, 16'hFFFF, 1'b1, 32'hFFFF_0000, 1'b0};
    vecs[3] = '{16'h0100, 16'h0100, 1'b1, 32'h0000_0000, 1'b1};
    vecs[4] = '{16'h0002, 16'h0003, 1'b0, 32'h0000_0006, 1'b0};
    vecs[5] = '{16'h0000, 16'hFFFF, 1'b0, 32'h0000_0000, 1'b0};
    vecs[6] = '{16'h0001, 16'h8001, 1'b0, 32'h0000_8001, 1'b0};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = 16'h0;
    bus.b = 16'h0;
    bus.acc_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.product", bus.product, 32'h0);
    chk("reset.ovf", {31'h0, bus.ovf}, 32'h0);
    chk("reset.ready", {31'h0, bus.ready}, 32'h1);
    chk("reset.busy", {31'h0, bus.busy}, 32'h0);
    chk("reset.done", {31'h0, bus.done}, 32'h0);
    rst_n = 1'b1;

    // Table: spec constants checked directly, and the value held while idle.
    for (int i = 0; i < 7; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].acc, 0);
      chk($sformatf("vec%0d.const", i), bus.product, vecs[i].p);
      chk($sformatf("vec%0d.const_ovf", i), {31'h0, bus.ovf}, {31'h0, vecs[i].o});
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d.hold", i), bus.product, vecs[i].p);
      chk($sformatf("vec%0d.hold_ovf", i), {31'h0, bus.ovf}, {31'h0, vecs[i].o});
    end

    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom), 1'($urandom_range(1)), 0);
    end

    // Start with new operands during P1 must be ignored.
    do_op("ignore_p1", 16'h1234, 16'h5678, 1'b0, 2);
    chk("ignore_p1.const", bus.product, 32'h0626_0060);
    @(negedge clk);
    chk("ignore_p1.idle", {29'h0, bus.ready, bus.busy, bus.done}, 32'h4);

    // Back-to-back with start held high through DONE.
    begin
      logic [15:0] ba [3];
      logic [15:0] bb [3];
      logic        bm [3];
      int cyc, last, n, idle_seen;
      ba[0] = 16'h00FF; bb[0] = 16'h0101; bm[0] = 1'b0;
      ba[1] = 16'h1000; bb[1] = 16'h0010; bm[1] = 1'b0;
      ba[2] = 16'h0003; bb[2] = 16'h0001; bm[2] = 1'b1;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = ba[0]; bus.b = bb[0]; bus.acc_mode = bm[0];
      expect_push(ba[0], bb[0], bm[0]);
      cyc = 0; last = 0; n = 0; idle_seen = 0;
      for (int k = 0; k < 40 && n < 3; k++) begin
        @(negedge clk);
        cyc++;
        if (bus.ready && !bus.done) idle_seen++;
        if (bus.done) begin
          sb_pop_check($sformatf("b2b%0d", n));
          chk($sformatf("b2b%0d.interval", n), cyc - last, 5);
          last = cyc;
          n++;
          if (n < 3) begin
            bus.a = ba[n]; bus.b = bb[n]; bus.acc_mode = bm[n];
            expect_push(ba[n], bb[n], bm[n]);
          end else begin
            bus.start = 1'b0;
          end
        end
      end
      chk("b2b.count", n, 3);
      chk("b2b.no_idle", idle_seen, 0);
      chk("b2b.last_const", bus.product, 32'h0001_0003);
      bus.start = 1'b0;
    end

    // Asynchronous reset during P2.
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'hABCD; bus.b = 16'h1234; bus.acc_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid.in_p2_busy", {31'h0, bus.busy}, 32'h1);
    chk("rst_mid.partial_nonzero", {31'h0, (bus.product != 32'h0)}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.product", bus.product, 32'h0);
    chk("rst_mid.flags", {29'h0, bus.ready, bus.busy, bus.done}, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    model_p = 32'h0;
    do_op("after_rst", 16'h0003, 16'h0005, 1'b0, 0);
    chk("after_rst.const", bus.product, 32'h0000_000F);

    chk("sb.empty", sbq.size(), 0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
